// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: cause codes,
// CSR bit positions and the sequencer state encoding.
package trap_pkg;

    localparam logic [31:0] CAUSE_MISALIGN = 32'h0000_0000;
    localparam logic [31:0] CAUSE_ILLEGAL  = 32'h0000_0002;
    localparam logic [31:0] CAUSE_BREAK    = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'h0000_000B;
    localparam logic [31:0] CAUSE_MTI      = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI      = 32'h8000_000B;

    localparam int unsigned MSTATUS_MIE = 3;
    localparam int unsigned MIE_MTIE    = 7;
    localparam int unsigned MIE_MEIE    = 11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTER    = 2'd1,
        ST_RET      = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_e;

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchronizer for a level-sensitive asynchronous interrupt line,
// cleared asynchronously by the active-low reset.
module irq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_x,
    input  logic d_async,
    output logic q_sync
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: prioritises exceptions, interrupts and mret from execute,
// strobes the CSR file and redirects fetch, stalling the pipe meanwhile.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter bit          VECTORED_EN = 1'b1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_x,
    input  logic        instr_valid,
    input  logic [31:0] pc_ex,
    input  logic        ecall_req,
    input  logic        ebreak_req,
    input  logic        illegal_req,
    input  logic        misalign_req,
    input  logic        mret_req,
    input  logic        ext_irq_async,
    input  logic        timer_irq,
    input  logic [31:0] mstatus,
    input  logic [31:0] mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        ecall,
    output logic        mret,
    output logic [31:0] mepc_in,
    output logic [31:0] mcause_in,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall,
    output logic        flush
);

    logic ext_sync;

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .clk    (clk),
        .reset_x(reset_x),
        .d_async(ext_irq_async),
        .q_sync (ext_sync)
    );

    trap_state_e state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] mepc_in_q, mepc_in_d;
    logic [31:0] mcause_in_q, mcause_in_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        ecall_q, ecall_d;
    logic        mret_q, mret_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic        stall_q, stall_d;
    logic        flush_q, flush_d;

    logic        ext_en, tmr_en;
    logic        trap_sel, is_irq;
    logic [31:0] cause;
    logic [31:0] base_tgt, entry_tgt;

    logic unused_csr_bits;
    assign unused_csr_bits = ^{mstatus[31:4], mstatus[2:0], mie[31:12], mie[10:8], mie[6:0]};

    always_comb begin
        ext_en = mstatus[MSTATUS_MIE] & mie[MIE_MEIE] & ext_sync;
        tmr_en = mstatus[MSTATUS_MIE] & mie[MIE_MTIE] & timer_irq;

        trap_sel = 1'b1;
        is_irq   = 1'b0;
        cause    = '0;
        if (ext_en) begin
            cause  = CAUSE_MEI;
            is_irq = 1'b1;
        end else if (tmr_en) begin
            cause  = CAUSE_MTI;
            is_irq = 1'b1;
        end else if (misalign_req) begin
            cause = CAUSE_MISALIGN;
        end else if (illegal_req) begin
            cause = CAUSE_ILLEGAL;
        end else if (ebreak_req) begin
            cause = CAUSE_BREAK;
        end else if (ecall_req) begin
            cause = CAUSE_ECALL_M;
        end else begin
            trap_sel = 1'b0;
        end

        // 4*cause[30:0] truncated to 32 bits keeps only cause[29:0]
        base_tgt  = {mtvec[31:2], 2'b00};
        entry_tgt = base_tgt;
        if (VECTORED_EN && is_irq && (mtvec[1:0] == 2'b01)) begin
            entry_tgt = base_tgt + {cause[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        mepc_in_d     = mepc_in_q;
        mcause_in_d   = mcause_in_q;
        redirect_pc_d = redirect_pc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (trap_sel) begin
                        state_d     = ST_ENTER;
                        mepc_in_d   = pc_ex;
                        mcause_in_d = cause;
                        target_d    = entry_tgt;
                    end else if (mret_req) begin
                        state_d  = ST_RET;
                        target_d = mepc;
                    end
                end
            end
            ST_ENTER, ST_RET: begin
                state_d       = ST_REDIRECT;
                redirect_pc_d = target_q;
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the state being entered
        ecall_d          = (state_d == ST_ENTER);
        mret_d           = (state_d == ST_RET);
        flush_d          = (state_d == ST_ENTER) || (state_d == ST_RET);
        redirect_valid_d = (state_d == ST_REDIRECT);
        stall_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q          <= ST_IDLE;
            target_q         <= '0;
            mepc_in_q        <= '0;
            mcause_in_q      <= '0;
            redirect_pc_q    <= '0;
            ecall_q          <= 1'b0;
            mret_q           <= 1'b0;
            redirect_valid_q <= 1'b0;
            stall_q          <= 1'b0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            mepc_in_q        <= mepc_in_d;
            mcause_in_q      <= mcause_in_d;
            redirect_pc_q    <= redirect_pc_d;
            ecall_q          <= ecall_d;
            mret_q           <= mret_d;
            redirect_valid_q <= redirect_valid_d;
            stall_q          <= stall_d;
            flush_q          <= flush_d;
        end
    end

    assign ecall          = ecall_q;
    assign mret           = mret_q;
    assign mepc_in        = mepc_in_q;
    assign mcause_in      = mcause_in_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall          = stall_q;
    assign flush          = flush_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed, table-driven bench for trap_ctrl with hand sequences for
// synchronizer latency and reset during an active sequence.
module tb_trap_ctrl;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        reset_x;
    logic        instr_valid;
    logic [31:0] pc_ex;
    logic        ecall_req, ebreak_req, illegal_req, misalign_req, mret_req;
    logic        ext_irq_async, timer_irq;
    logic [31:0] mstatus, mie, mtvec, mepc;
    logic        ecall, mret, redirect_valid, stall, flush;
    logic [31:0] mepc_in, mcause_in, redirect_pc;

    trap_ctrl #(
        .VECTORED_EN(1'b1),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk           (clk),
        .reset_x       (reset_x),
        .instr_valid   (instr_valid),
        .pc_ex         (pc_ex),
        .ecall_req     (ecall_req),
        .ebreak_req    (ebreak_req),
        .illegal_req   (illegal_req),
        .misalign_req  (misalign_req),
        .mret_req      (mret_req),
        .ext_irq_async (ext_irq_async),
        .timer_irq     (timer_irq),
        .mstatus       (mstatus),
        .mie           (mie),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .ecall         (ecall),
        .mret          (mret),
        .mepc_in       (mepc_in),
        .mcause_in     (mcause_in),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .flush         (flush)
    );

    always #5 clk = ~clk;

    // req = {misalign, illegal, ebreak, ecall, mret}
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  req;
        logic        ext;
        logic        tmr;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        is_mret;
        logic [31:0] e_mepc;
        logic [31:0] e_cause;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        instr_valid  = 1'b0;
        ecall_req    = 1'b0;
        ebreak_req   = 1'b0;
        illegal_req  = 1'b0;
        misalign_req = 1'b0;
        mret_req     = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        @(negedge clk);
        clear_reqs();
        pc_ex         = v.pc;
        misalign_req  = v.req[4];
        illegal_req   = v.req[3];
        ebreak_req    = v.req[2];
        ecall_req     = v.req[1];
        mret_req      = v.req[0];
        ext_irq_async = v.ext;
        timer_irq     = v.tmr;
        mstatus       = v.mstatus;
        mie           = v.mie;
        mtvec         = v.mtvec;
        mepc          = v.mepc;
        // let the synchronizer settle on the new interrupt level
        repeat (SYNC + 1) @(negedge clk);
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        t = $sformatf("v%0d", idx);
        chk({t, "_ecall"},  {31'd0, ecall}, {31'd0, !v.is_mret});
        chk({t, "_mret"},   {31'd0, mret},  {31'd0, v.is_mret});
        chk({t, "_stall1"}, {31'd0, stall}, 32'd1);
        chk({t, "_flush1"}, {31'd0, flush}, 32'd1);
        chk({t, "_rv1"},    {31'd0, redirect_valid}, 32'd0);
        chk({t, "_mepc_in"},   mepc_in,   v.e_mepc);
        chk({t, "_mcause_in"}, mcause_in, v.e_cause);
        @(negedge clk);
        clear_reqs();
        @(posedge clk);
        #1;
        chk({t, "_rv2"},     {31'd0, redirect_valid}, 32'd1);
        chk({t, "_rpc"},     redirect_pc, v.e_pc);
        chk({t, "_stall2"},  {31'd0, stall}, 32'd1);
        chk({t, "_flush2"},  {31'd0, flush}, 32'd0);
        chk({t, "_strobe2"}, {30'd0, ecall, mret}, 32'd0);
        @(posedge clk);
        #1;
        chk({t, "_idle"},      {29'd0, stall, redirect_valid, ecall}, 32'd0);
        chk({t, "_mepc_hold"}, mepc_in, v.e_mepc);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, "_ctl"}, {27'd0, ecall, mret, redirect_valid, stall, flush}, 32'd0);
        chk({t, "_mepc_in"}, mepc_in, 32'd0);
        chk({t, "_mcause_in"}, mcause_in, 32'd0);
        chk({t, "_rpc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h100, 5'b00010, 1'b0, 1'b0, 32'h0, 32'h0,   32'h200,      32'h0,    1'b0, 32'h100, 32'hB,        32'h200};
        vecs[1]  = '{32'h0,   5'b00001, 1'b0, 1'b0, 32'h0, 32'h0,   32'h200,      32'h104,  1'b1, 32'h100, 32'hB,        32'h104};
        vecs[2]  = '{32'h40,  5'b00010, 1'b0, 1'b1, 32'h8, 32'h80,  32'h201,      32'h0,    1'b0, 32'h40,  32'h8000_0007, 32'h21C};
        vecs[3]  = '{32'h80,  5'b01000, 1'b1, 1'b1, 32'h0, 32'h880, 32'h301,      32'h0,    1'b0, 32'h80,  32'h2,        32'h300};
        vecs[4]  = '{32'h84,  5'b11111, 1'b0, 1'b0, 32'h0, 32'h0,   32'h200,      32'h500,  1'b0, 32'h84,  32'h0,        32'h200};
        vecs[5]  = '{32'h88,  5'b00111, 1'b0, 1'b0, 32'h0, 32'h0,   32'h200,      32'h500,  1'b0, 32'h88,  32'h3,        32'h200};
        vecs[6]  = '{32'h90,  5'b00000, 1'b1, 1'b1, 32'h8, 32'h880, 32'h201,      32'h0,    1'b0, 32'h90,  32'h8000_000B, 32'h22C};
        vecs[7]  = '{32'h94,  5'b00000, 1'b1, 1'b0, 32'h8, 32'h800, 32'h400,      32'h0,    1'b0, 32'h94,  32'h8000_000B, 32'h400};
        vecs[8]  = '{32'hA0,  5'b00000, 1'b0, 1'b1, 32'h8, 32'h80,  32'hFFFF_FFF1, 32'h0,   1'b0, 32'hA0,  32'h8000_0007, 32'hC};
        vecs[9]  = '{32'h0,   5'b00001, 1'b0, 1'b1, 32'h8, 32'h800, 32'h200,      32'h2000, 1'b1, 32'hA0,  32'h8000_0007, 32'h2000};
        vecs[10] = '{32'hA4,  5'b01001, 1'b0, 1'b0, 32'h0, 32'h0,   32'h200,      32'h700,  1'b0, 32'hA4,  32'h2,        32'h200};
        vecs[11] = '{32'hA8,  5'b00000, 1'b0, 1'b1, 32'h8, 32'h80,  32'h202,      32'h0,    1'b0, 32'hA8,  32'h8000_0007, 32'h200};

        reset_x = 1'b0;
        clear_reqs();
        pc_ex = '0; ext_irq_async = 1'b0; timer_irq = 1'b0;
        mstatus = '0; mie = '0; mtvec = '0; mepc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_x = 1'b1;

        // a request without instr_valid is not taken
        ecall_req = 1'b1; mtvec = 32'h200; pc_ex = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        chk("no_valid_ctl", {27'd0, ecall, mret, redirect_valid, stall, flush}, 32'd0);
        @(negedge clk);
        clear_reqs();

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // external interrupt is eligible only after the synchronizer delay
        @(negedge clk);
        clear_reqs();
        ext_irq_async = 1'b0; timer_irq = 1'b0;
        mstatus = 32'h8; mie = 32'h800; mtvec = 32'h300; pc_ex = 32'hC0;
        repeat (SYNC + 1) @(negedge clk);
        instr_valid = 1'b1;
        ext_irq_async = 1'b1;
        for (int e = 1; e <= int'(SYNC); e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sync_early_e%0d", e), {31'd0, ecall}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("sync_ecall", {31'd0, ecall}, 32'd1);
        chk("sync_cause", mcause_in, 32'h8000_000B);
        chk("sync_mepc", mepc_in, 32'hC0);
        @(negedge clk);
        clear_reqs();
        ext_irq_async = 1'b0;
        @(posedge clk);
        #1;
        chk("sync_rpc", redirect_pc, 32'h300);
        repeat (SYNC + 2) @(posedge clk);
        #1;
        chk("sync_no_retake", {31'd0, stall}, 32'd0);

        // reset asserted while in ENTER clears everything at once
        @(negedge clk);
        mstatus = '0; mie = '0; mtvec = 32'h200; pc_ex = 32'hD0;
        ecall_req = 1'b1; instr_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pre_ecall", {31'd0, ecall}, 32'd1);
        #1;
        reset_x = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge clk);
        clear_reqs();
        @(negedge clk);
        reset_x = 1'b1;
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer directly upstream of the machine-mode CSR file. It samples exception, interrupt and mret requests from the execute stage and picks one by priority. It then drives the CSR file's trap-entry strobe (ecall), mret strobe, mepc_in and mcause_in, and redirects fetch to the trap vector or to mepc. The pipeline is stalled and flushed while the sequence runs.

Parameters:
VECTORED_EN, 1, 1 = honour mtvec[1:0]==2'b01 vectored mode for interrupts; 0 = always direct
SYNC_STAGES, 2, flop stages on the asynchronous external-interrupt input (min 2)

Ports:
clk  in  1  system clock, all state on rising edge
reset_x  in  1  asynchronous, active-low reset
instr_valid  in  1  execute stage holds a valid instruction
pc_ex  in  32  PC of the execute-stage instruction
ecall_req  in  1  ECALL decoded
ebreak_req  in  1  EBREAK decoded
illegal_req  in  1  illegal instruction
misalign_req  in  1  instruction-address misaligned
mret_req  in  1  MRET decoded
ext_irq_async  in  1  external interrupt, asynchronous, level
timer_irq  in  1  timer interrupt, synchronous, level
mstatus  in  32  current mstatus from CSR file (bit 3 = MIE)
mie  in  32  current mie (bit 7 = MTIE, bit 11 = MEIE)
mtvec  in  32  current mtvec
mepc  in  32  current mepc
ecall  out  1  trap-entry strobe to CSR file
mret  out  1  return strobe to CSR file
mepc_in  out  32  PC to save
mcause_in  out  32  cause to save
redirect_valid  out  1  fetch redirect, one cycle
redirect_pc  out  32  redirect target
stall  out  1  freeze upstream stages
flush  out  1  kill the execute-stage instruction

Behaviour:
- Reset (reset_x=0, any time, including mid-sequence): state=IDLE, synchronizer cleared. All outputs 0: ecall, mret, redirect_valid, stall, flush, mepc_in, mcause_in, redirect_pc.
- All outputs are registered. The CSR file writes on the falling edge, so strobes must be stable for the whole high phase.
- Interrupt enable terms:
  - ext_en = mstatus[3] & mie[11] & ext_sync
  - tmr_en = mstatus[3] & mie[7] & timer_irq
- Requests are evaluated only in IDLE and only when instr_valid=1.
- Priority, highest first:
  - ext interrupt: cause 32'h8000000B
  - timer interrupt: 32'h80000007
  - misalign: 32'h0
  - illegal: 32'h2
  - ebreak: 32'h3
  - ecall: 32'hB
  - mret (lowest; ignored if any trap is selected)
- FSM states: IDLE, ENTER, RET, REDIRECT.
  - IDLE→ENTER on a selected trap. Latch mepc_in=pc_ex and mcause_in=cause. Latch the target:
    - direct mode: {mtvec[31:2],2'b00}
    - vectored mode (VECTORED_EN=1, mtvec[1:0]=01, interrupt): {mtvec[31:2],2'b00} + 4*cause[30:0]
  - IDLE→RET on mret_req with no trap. Latch target = mepc.
  - ENTER (exactly 1 cycle): ecall=1, stall=1, flush=1. Next state REDIRECT.
  - RET (exactly 1 cycle): mret=1, stall=1, flush=1. Next state REDIRECT.
  - REDIRECT (exactly 1 cycle): redirect_valid=1, redirect_pc=latched target, stall=1. Next state IDLE.
- Latency: request seen at rising edge N → ecall/mret high during cycle N+1 → redirect_valid during cycle N+2 → IDLE accepts new requests at edge N+3.
- Requests and interrupt changes while not in IDLE are ignored. Upstream is stalled, so exceptions are re-presented. Interrupts are level-sensitive, so they are retaken if still pending.
- Vectored offset arithmetic is 32-bit and wraps modulo 2^32.
- mepc_in/mcause_in hold their last value outside ENTER.
- ext_irq_async passes through SYNC_STAGES flops before use. Latency from an async edge to eligibility is SYNC_STAGES cycles.

Decomposition:
- Package trap_pkg holds:
  - cause constants: CAUSE_MISALIGN, CAUSE_ILLEGAL, CAUSE_BREAK, CAUSE_ECALL_M, CAUSE_MTI, CAUSE_MEI
  - CSR bit positions: MSTATUS_MIE=3, MIE_MTIE=7, MIE_MEIE=11
  - FSM state encoding
- One sub-module, irq_sync: parameterised SYNC_STAGES flop chain with asynchronous active-low clear on reset_x.

Test Plan:
1. ECALL: pc_ex=32'h100, ecall_req=1, mtvec=32'h200 → ecall pulse 1 cycle with mepc_in=32'h100, mcause_in=32'hB. Next cycle redirect_valid=1, redirect_pc=32'h200; stall high for 2 cycles.
2. MRET: mepc=32'h104, mret_req=1 → mret pulse 1 cycle, then redirect_pc=32'h104; no ecall pulse.
3. Vectored timer interrupt: mstatus[3]=1, mie[7]=1, timer_irq=1, ecall_req=1, mtvec=32'h201, pc_ex=32'h40 → mcause_in=32'h80000007, mepc_in=32'h40, redirect_pc=32'h21C. The simultaneous ECALL is not taken.
4. Masked interrupts: mstatus[3]=0, ext_irq_async=1, illegal_req=1 → mcause_in=32'h2.
5. Sync latency: ext_irq_async rises with MIE/MEIE=1 → ecall pulse no earlier than SYNC_STAGES+1 cycles later; mcause_in=32'h8000000B.
6. Reset mid-operation: drop reset_x while in ENTER → all outputs 0 immediately. After release, the FSM is in IDLE and a fresh ecall_req is serviced normally.
